instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the synchronous instruction ROM (clk, 10-bit word addr, 32-bit dout, one-cycle read latency).
- Owns the program counter and drives the ROM word address.
- Realigns the ROM's registered output with its PC and presents instr/pc/pc_plus4/valid to the decode stage.
- Handles decode stalls (hold buffer) and branch/jump redirects (one-cycle bubble).

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- ADDR_W, 10, ROM word-address width; rom_addr = pc[ADDR_W+1:2].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rom_addr  output  ADDR_W  word address to ROM, equals pc_q[ADDR_W+1:2].
- rom_dout  input  32  ROM read data (word at rom_addr sampled on previous edge).
- stall  input  1  decode not accepting; hold current output.
- redirect  input  1  branch/jump taken this cycle.
- target  input  32  redirect byte address; bits [1:0] ignored (treated as 0).
- instr  output  32  instruction to decode.
- pc  output  32  byte address of instr.
- pc_plus4  output  32  pc + 4, wraps mod 2^32.
- valid  output  1  instr/pc are meaningful.

Behaviour:
- Internal regs: pc_q (address presented to ROM), f_pc (address of word on rom_dout), f_valid, hold_instr, hold_valid.
- Reset (async, any time incl. mid-stall/mid-redirect): pc_q=RESET_PC with [1:0] forced 0, f_pc=0, f_valid=0, hold_valid=0, hold_instr=0.
  - Outputs during reset: valid=0, pc=0, pc_plus4=4, instr=rom_dout (don't-care), rom_addr=RESET_PC[ADDR_W+1:2].
- Outputs: instr = hold_valid ? hold_instr : rom_dout; pc = f_pc; pc_plus4 = f_pc+4; valid = f_valid.
- Priority per edge: rst > redirect > stall > advance.
- Advance (no stall, no redirect): pc_q<=pc_q+4; f_pc<=pc_q; f_valid<=1; hold_valid<=0.
- Stall, no redirect: pc_q, f_pc, f_valid hold.
  - If f_valid & !hold_valid: hold_instr<=rom_dout, hold_valid<=1. The ROM re-samples pc_q, so the held word must survive.
  - While stalled, instr/pc are stable across all cycles.
- Stall release: the edge with stall=0 is the consume edge. The normal advance applies and hold_valid clears. The next output is the word at the old pc_q, with no gap.
- Redirect (overrides stall): pc_q<={target[31:2],2'b00}; f_valid<=0; hold_valid<=0.
  - Next cycle valid=0 (one bubble).
  - The following edge yields f_pc=target, valid=1.
- Redirect while valid=0: same rule; the newest target wins.
- Stall while valid=0: no capture; state holds.
- Address wrap:
  - pc_q wraps mod 2^32.
  - rom_addr uses only pc_q[ADDR_W+1:2], so fetch wraps modulo 2^ADDR_W words.
  - Word 1023 is followed by word 0 at pc 0x1000.
- Latency: reset release to first valid = 1 edge. Redirect to valid target instr = 2 edges.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: extra outputs fetch_cnt[31:0] and bubble_cnt[31:0], both reset to 0.
  - fetch_cnt increments on each edge with valid & !stall & !redirect.
  - bubble_cnt increments on each edge with !valid & !rst.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Bench uses a behavioural 1-cycle ROM stub with word[i]=32'hC000_0000+i.
- Reset then free-run, RESET_PC=0 -> valid=0 during rst; first edge after release gives pc=0, instr=C0000000; then pc=4 instr=C0000001, pc=8 instr=C0000002, pc_plus4=pc+4.
- Stall 3 cycles at pc=8 -> instr=C0000002, pc=8 held all 3 cycles; after release, next outputs are pc=0xC instr=C0000003 with no skip or duplicate.
- Redirect target=0x7C at pc=0x10 -> one cycle valid=0, then pc=0x7C instr=C000001F, then pc=0x80 instr=C0000020.
- Redirect and stall asserted together, target=0xCFD -> redirect wins, hold cleared, then pc=0xCFC instr=C000033F (address 831).
- Run to pc=0xFFC (instr=C00003FF) -> next pc=0x1000, rom_addr=0, instr=C0000000.
- Assert rst mid-stall with hold_valid=1 -> valid=0 immediately; after release fetch restarts at pc=0; with FETCH_PERF_CNT_EN both counters read 0.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, drives the sync instruction ROM, realigns its output.
// Optional macro FETCH_PERF_CNT_EN adds fetch_cnt / bubble_cnt outputs.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_dout,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       target,
    output logic [31:0]       instr,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic              valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_W = RESET_PC & WORD_MASK;

    logic [31:0] pc_q;
    logic [31:0] f_pc;
    logic        f_valid;
    logic [31:0] hold_instr;
    logic        hold_valid;

    assign rom_addr = pc_q[ADDR_W+1:2];
    assign instr    = hold_valid ? hold_instr : rom_dout;
    assign pc       = f_pc;
    assign pc_plus4 = f_pc + 32'd4;
    assign valid    = f_valid;

    // PC / realignment state: redirect beats stall, stall beats advance.
    // While stalled the ROM re-reads pc_q, so the word on display is
    // captured into the hold buffer on the first stalled edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC_W;
            f_pc       <= 32'd0;
            f_valid    <= 1'b0;
            hold_instr <= 32'd0;
            hold_valid <= 1'b0;
        end else if (redirect) begin
            pc_q       <= target & WORD_MASK;
            f_valid    <= 1'b0;
            hold_valid <= 1'b0;
        end else if (stall) begin
            if (f_valid && !hold_valid) begin
                hold_instr <= rom_dout;
                hold_valid <= 1'b1;
            end
        end else begin
            pc_q       <= pc_q + 32'd4;
            f_pc       <= pc_q;
            f_valid    <= 1'b1;
            hold_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Consumed-instruction and bubble counters, both free-wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt  <= 32'd0;
            bubble_cnt <= 32'd0;
        end else begin
            if (f_valid && !stall && !redirect)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (!f_valid)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed + randomized checks of instr_fetch
// against a PC-stream reference model and a 1-cycle ROM stub.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [9:0]  rom_addr;
    logic [31:0] rom_dout;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    int checks;
    int failures;

    // reference model: what decode should see
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_next;
    logic [31:0] m_fetch;
    logic [31:0] m_bubble;

    instr_fetch dut (
        .clk      (clk),
        .rst      (rst),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .stall    (stall),
        .redirect (redirect),
        .target   (target),
        .instr    (instr),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .valid    (valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM stub: word[i] = C000_0000 + i, one-cycle latency
    always @(posedge clk)
        rom_dout <= 32'hC000_0000 + {22'd0, rom_addr};

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hC000_0000 + {22'd0, a[11:2]};
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_pc     = 32'd0;
        m_next   = 32'd0;
        m_fetch  = 32'd0;
        m_bubble = 32'd0;
    endtask

    // drive one cycle and advance the model by the same edge
    task automatic step(input logic s, input logic r,
                        input logic [31:0] t);
        stall    = s;
        redirect = r;
        target   = t;
        @(posedge clk);
        if (m_valid && !s && !r) m_fetch = m_fetch + 1;
        if (!m_valid) m_bubble = m_bubble + 1;
        if (r) begin
            m_valid = 1'b0;
            m_next  = t & 32'hFFFF_FFFC;
        end else if (!s) begin
            m_pc    = m_next;
            m_valid = 1'b1;
            m_next  = m_next + 32'd4;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 0; redirect = 0; target = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid got=%b exp=0", valid);
        end
        checks++;
        if (pc !== 32'd0 || pc_plus4 !== 32'd4) begin
            failures++;
            $display("FAIL rst_pc got=%h/%h exp=0/4", pc, pc_plus4);
        end
        checks++;
        if (rom_addr !== 10'd0) begin
            failures++;
            $display("FAIL rst_rom_addr got=%h exp=0", rom_addr);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (fetch_cnt !== 0 || bubble_cnt !== 0) begin
            failures++;
            $display("FAIL rst_cnt got=%0d/%0d exp=0/0",
                     fetch_cnt, bubble_cnt);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            checks++;
            if (valid !== 1'b1 || pc !== 32'(i * 4)) begin
                failures++;
                $display("FAIL run_pc[%0d] got=%b/%h exp=1/%h",
                         i, valid, pc, 32'(i * 4));
            end
            checks++;
            if (instr !== 32'hC000_0000 + 32'(i)) begin
                failures++;
                $display("FAIL run_instr[%0d] got=%h exp=%h",
                         i, instr, 32'hC000_0000 + 32'(i));
            end
            checks++;
            if (pc_plus4 !== 32'(i * 4 + 4)) begin
                failures++;
                $display("FAIL run_pc4[%0d] got=%h exp=%h",
                         i, pc_plus4, 32'(i * 4 + 4));
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            checks++;
            if (valid !== 1'b1 || pc !== 32'h8 ||
                instr !== 32'hC000_0002) begin
                failures++;
                $display("FAIL stall_hold[%0d] got=%b/%h/%h exp=1/8/c0000002",
                         i, valid, pc, instr);
            end
        end
        step(0, 0, 0);
        checks++;
        if (valid !== 1'b1 || pc !== 32'hC ||
            instr !== 32'hC000_0003) begin
            failures++;
            $display("FAIL stall_release got=%b/%h/%h exp=1/c/c0000003",
                     valid, pc, instr);
        end
        step(0, 0, 0);
    endtask

    task automatic test_redirect();
        checks++;
        if (pc !== 32'h10) begin
            failures++;
            $display("FAIL redir_start got=%h exp=10", pc);
        end
        step(0, 1, 32'h7C);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_bubble got=%b exp=0", valid);
        end
        step(0, 0, 0);
        checks++;
        if (valid !== 1'b1 || pc !== 32'h7C ||
            instr !== 32'hC000_001F) begin
            failures++;
            $display("FAIL redir_tgt got=%b/%h/%h exp=1/7c/c000001f",
                     valid, pc, instr);
        end
        step(0, 0, 0);
        checks++;
        if (valid !== 1'b1 || pc !== 32'h80 ||
            instr !== 32'hC000_0020) begin
            failures++;
            $display("FAIL redir_next got=%b/%h/%h exp=1/80/c0000020",
                     valid, pc, instr);
        end
    endtask

    task automatic test_redirect_stall();
        step(1, 0, 0);
        step(1, 1, 32'hCFD);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL rs_bubble got=%b exp=0", valid);
        end
        step(0, 0, 0);
        checks++;
        if (valid !== 1'b1 || pc !== 32'hCFC ||
            instr !== 32'hC000_033F) begin
            failures++;
            $display("FAIL rs_tgt got=%b/%h/%h exp=1/cfc/c000033f",
                     valid, pc, instr);
        end
    endtask

    task automatic test_wrap();
        step(0, 1, 32'hFF0);
        while (m_pc !== 32'hFFC || !m_valid) step(0, 0, 0);
        checks++;
        if (pc !== 32'hFFC || instr !== 32'hC000_03FF ||
            rom_addr !== 10'd0) begin
            failures++;
            $display("FAIL wrap_last got=%h/%h/%h exp=ffc/c00003ff/0",
                     pc, instr, rom_addr);
        end
        step(0, 0, 0);
        checks++;
        if (valid !== 1'b1 || pc !== 32'h1000 ||
            instr !== 32'hC000_0000) begin
            failures++;
            $display("FAIL wrap_first got=%b/%h/%h exp=1/1000/c0000000",
                     valid, pc, instr);
        end
    endtask

    task automatic test_random();
        logic s, r;
        logic [31:0] t;
        for (int n = 0; n < 400; n++) begin
            s = ($urandom_range(0, 9) < 3);
            r = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: t = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                1: t = 32'h0000_0FF0 + $urandom_range(0, 15);
                default: t = $urandom;
            endcase
            step(s, r, t);
            checks++;
            if (valid !== m_valid) begin
                failures++;
                $display("FAIL rnd_valid[%0d] got=%b exp=%b",
                         n, valid, m_valid);
            end
            checks++;
            if (rom_addr !== m_next[11:2]) begin
                failures++;
                $display("FAIL rnd_rom_addr[%0d] got=%h exp=%h",
                         n, rom_addr, m_next[11:2]);
            end
            if (m_valid) begin
                checks++;
                if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4) begin
                    failures++;
                    $display("FAIL rnd_pc[%0d] got=%h/%h exp=%h/%h",
                             n, pc, pc_plus4, m_pc, m_pc + 32'd4);
                end
                checks++;
                if (instr !== word_of(m_pc)) begin
                    failures++;
                    $display("FAIL rnd_instr[%0d] got=%h exp=%h",
                             n, instr, word_of(m_pc));
                end
            end
`ifdef FETCH_PERF_CNT_EN
            checks++;
            if (fetch_cnt !== m_fetch || bubble_cnt !== m_bubble) begin
                failures++;
                $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d",
                         n, fetch_cnt, bubble_cnt, m_fetch, m_bubble);
            end
`endif
        end
    endtask

    task automatic test_reset_mid_stall();
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        #2;
        rst = 1'b1;
        stall = 1'b0;
        model_reset();
        #1;
        checks++;
        if (valid !== 1'b0 || pc !== 32'd0) begin
            failures++;
            $display("FAIL mid_rst got=%b/%h exp=0/0", valid, pc);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (fetch_cnt !== 0 || bubble_cnt !== 0) begin
            failures++;
            $display("FAIL mid_rst_cnt got=%0d/%0d exp=0/0",
                     fetch_cnt, bubble_cnt);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 0);
        checks++;
        if (valid !== 1'b1 || pc !== 32'd0 ||
            instr !== 32'hC000_0000) begin
            failures++;
            $display("FAIL mid_rst_restart got=%b/%h/%h exp=1/0/c0000000",
                     valid, pc, instr);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_random();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
